pwm_duty_decoder: RTL



---
 rtl/pwm_duty_decoder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pwm_duty_decoder.sv
// Recovers high time and period length (in clk cycles) of each PWM period on a
// single-bit line, with a one-cycle valid strobe and a timeout report for a stuck line.
module pwm_duty_decoder #(
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 2048
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] duty,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 valid,
    output logic                 stuck,
    output logic                 locked
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT     = CNT_WIDTH'(1);

    state_t                 state;
    state_t                 state_nxt;
    logic                   s1;
    logic                   s2;
    logic                   s3;
    logic                   level;
    logic                   rise;
    logic [CNT_WIDTH-1:0]   period_cnt;
    logic [CNT_WIDTH-1:0]   high_cnt;
    logic [CNT_WIDTH-1:0]   period_cnt_nxt;
    logic [CNT_WIDTH-1:0]   high_cnt_nxt;
    logic [CNT_WIDTH-1:0]   duty_nxt;
    logic [CNT_WIDTH-1:0]   period_nxt;
    logic                   valid_nxt;
    logic                   stuck_nxt;

    assign level  = s2;
    assign rise   = s2 & ~s3;
    assign locked = (state == MEASURE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The rising-edge cycle is the first high cycle of the new period, so both
    // counters restart at 1 and high_cnt <= period_cnt <= TIMEOUT always holds.
    always_comb begin
        state_nxt      = state;
        period_cnt_nxt = period_cnt;
        high_cnt_nxt   = high_cnt;
        duty_nxt       = duty;
        period_nxt     = period;
        stuck_nxt      = stuck;
        valid_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    period_cnt_nxt = ONE_CNT;
                    high_cnt_nxt   = ONE_CNT;
                    state_nxt      = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    duty_nxt       = high_cnt;
                    period_nxt     = period_cnt;
                    stuck_nxt      = 1'b0;
                    valid_nxt      = 1'b1;
                    period_cnt_nxt = ONE_CNT;
                    high_cnt_nxt   = ONE_CNT;
                end else if (period_cnt == TIMEOUT_CNT) begin
                    period_nxt     = TIMEOUT_CNT;
                    duty_nxt       = level ? TIMEOUT_CNT : '0;
                    stuck_nxt      = 1'b1;
                    valid_nxt      = 1'b1;
                    period_cnt_nxt = '0;
                    high_cnt_nxt   = '0;
                    state_nxt      = IDLE;
                end else begin
                    period_cnt_nxt = period_cnt + ONE_CNT;
                    high_cnt_nxt   = high_cnt + {{(CNT_WIDTH-1){1'b0}}, level};
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            period_cnt <= '0;
            high_cnt   <= '0;
            duty       <= '0;
            period     <= '0;
            valid      <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            s1         <= pwm_in;
            s2         <= s1;
            s3         <= s2;
            period_cnt <= period_cnt_nxt;
            high_cnt   <= high_cnt_nxt;
            duty       <= duty_nxt;
            period     <= period_nxt;
            valid      <= valid_nxt;
            stuck      <= stuck_nxt;
        end
    end

endmodule
